// File: rtl/mem_request_arbiter.sv
// Two-requester round-robin arbiter in front of a RAM/ROM controller.
// Latches the winner's request, launches it, and reports done/timeout per requester.
module mem_request_arbiter #(
  parameter int unsigned ADDRESS_SIZE   = 24,
  parameter int unsigned DATA_SIZE      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0,
  input  logic                    req1,
  input  logic [ADDRESS_SIZE-1:0] addr0,
  input  logic [ADDRESS_SIZE-1:0] addr1,
  input  logic [DATA_SIZE-1:0]    wdata0,
  input  logic [DATA_SIZE-1:0]    wdata1,
  input  logic                    cs0,
  input  logic                    cs1,
  input  logic                    len0,
  input  logic                    len1,
  input  logic                    op0,
  input  logic                    op1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    done0,
  output logic                    done1,
  output logic                    err0,
  output logic                    err1,
  output logic [DATA_SIZE-1:0]    rdata,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0]    mem_wdata,
  output logic                    mem_chipSelect,
  output logic                    mem_lengthSelect,
  output logic                    mem_opSelect,
  output logic                    mem_start,
  input  logic [DATA_SIZE-1:0]    mem_rdata,
  input  logic                    mem_ack,
  input  logic                    mem_ready
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN    = (TIMEOUT_CYCLES != 32'd0);

  state_t                  r_state;
  logic                    r_owner;
  logic                    r_last;
  logic [15:0]             r_cnt;
  logic [DATA_SIZE-1:0]    r_rdata;
  logic [ADDRESS_SIZE-1:0] r_addr;
  logic [DATA_SIZE-1:0]    r_wdata;
  logic                    r_cs;
  logic                    r_len;
  logic                    r_op;
  logic                    r_start;
  logic [1:0]              r_gnt;
  logic [1:0]              r_done;
  logic [1:0]              r_err;

  state_t                  w_state;
  logic                    w_owner;
  logic                    w_last;
  logic [15:0]             w_cnt;
  logic [DATA_SIZE-1:0]    w_rdata;
  logic [ADDRESS_SIZE-1:0] w_addr;
  logic [DATA_SIZE-1:0]    w_wdata;
  logic                    w_cs;
  logic                    w_len;
  logic                    w_op;
  logic                    w_start;
  logic [1:0]              w_gnt;
  logic [1:0]              w_done;
  logic [1:0]              w_err;
  logic                    w_sel;
  logic                    w_timeout;

  // On a tie the requester that was not served last wins.
  assign w_sel     = (req0 && req1) ? ~r_last : req1;
  assign w_timeout = TIMEOUT_EN && ((r_cnt + 16'd1) == TIMEOUT_LIMIT);

  // Next-state and next-register values; every output is registered.
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last  = r_last;
    w_cnt   = r_cnt;
    w_rdata = r_rdata;
    w_addr  = r_addr;
    w_wdata = r_wdata;
    w_cs    = r_cs;
    w_len   = r_len;
    w_op    = r_op;
    w_start = 1'b0;
    w_gnt   = 2'b00;
    w_done  = 2'b00;
    w_err   = 2'b00;
    case (r_state)
      S_IDLE: begin
        if (mem_ready && (req0 || req1)) begin
          w_state = S_ISSUE;
          w_owner = w_sel;
          w_addr  = w_sel ? addr1  : addr0;
          w_wdata = w_sel ? wdata1 : wdata0;
          w_cs    = w_sel ? cs1    : cs0;
          w_len   = w_sel ? len1   : len0;
          w_op    = w_sel ? op1    : op0;
          w_gnt   = {w_sel, ~w_sel};
          w_start = 1'b1;
        end else begin
          w_state = S_IDLE;
        end
      end
      S_ISSUE: begin
        w_state = S_WAIT;
        w_cnt   = 16'd0;
      end
      S_WAIT: begin
        // An ack in the same cycle as the timeout takes priority.
        if (mem_ack) begin
          w_state = S_DONE;
          w_done  = {r_owner, ~r_owner};
          w_last  = r_owner;
          if (!r_op) begin
            w_rdata = mem_rdata;
          end else begin
            w_rdata = r_rdata;
          end
        end else if (w_timeout) begin
          w_state = S_IDLE;
          w_err   = {r_owner, ~r_owner};
          w_last  = r_owner;
        end else begin
          w_cnt = r_cnt + 16'd1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_cnt   <= 16'd0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cs    <= 1'b0;
      r_len   <= 1'b0;
      r_op    <= 1'b0;
      r_start <= 1'b0;
      r_gnt   <= 2'b00;
      r_done  <= 2'b00;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_cnt   <= w_cnt;
      r_rdata <= w_rdata;
      r_addr  <= w_addr;
      r_wdata <= w_wdata;
      r_cs    <= w_cs;
      r_len   <= w_len;
      r_op    <= w_op;
      r_start <= w_start;
      r_gnt   <= w_gnt;
      r_done  <= w_done;
      r_err   <= w_err;
    end
  end

  assign gnt0             = r_gnt[0];
  assign gnt1             = r_gnt[1];
  assign done0            = r_done[0];
  assign done1            = r_done[1];
  assign err0             = r_err[0];
  assign err1             = r_err[1];
  assign rdata            = r_rdata;
  assign mem_addr         = r_addr;
  assign mem_wdata        = r_wdata;
  assign mem_chipSelect   = r_cs;
  assign mem_lengthSelect = r_len;
  assign mem_opSelect     = r_op;
  assign mem_start        = r_start;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: a vector table of single transactions
// plus hand-written sequences for tie ordering, reset mid-write and backpressure.
module tb_mem_request_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [23:0] addr0 = 24'd0, addr1 = 24'd0;
  logic [15:0] wdata0 = 16'd0, wdata1 = 16'd0;
  logic        cs0 = 1'b0, cs1 = 1'b0, len0 = 1'b0, len1 = 1'b0, op0 = 1'b0, op1 = 1'b0;
  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [15:0] rdata;
  logic [23:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_chipSelect, mem_lengthSelect, mem_opSelect, mem_start;
  logic [15:0] mem_rdata = 16'd0;
  logic        mem_ack = 1'b0;
  logic        mem_ready = 1'b0;

  mem_request_arbiter #(
    .ADDRESS_SIZE  (24),
    .DATA_SIZE     (16),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .cs0(cs0), .cs1(cs1), .len0(len0), .len1(len1), .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err0(err0), .err1(err1),
    .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_chipSelect(mem_chipSelect), .mem_lengthSelect(mem_lengthSelect),
    .mem_opSelect(mem_opSelect), .mem_start(mem_start),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;        // {req1, req0}
    logic [23:0] addr;       // addr0; addr1 gets the inverse
    logic [15:0] wdata;      // wdata0; wdata1 gets the inverse
    logic        cs;
    logic        len;
    logic        op;
    int          ack_wait;   // WAIT cycle index carrying mem_ack, -1 = never
    logic [15:0] mrdata;
    logic        exp_owner;
    logic        exp_err;
    int          exp_w;      // WAIT cycle index at whose end done/err is pulsed
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t        vecs [6];
  vec_t        v;
  int          n_checks = 0;
  int          n_fail = 0;
  int          w;
  int          n_g;
  logic        got;
  logic        flag;
  logic [3:0]  order;
  logic [3:0]  exp_pulse;
  logic [23:0] exp_addr;
  logic [15:0] exp_wd;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //         req    addr        wdata     cs    len   op   ack  mrdata    own   err   w   exp_rdata
    vecs[0] = '{2'b01, 24'h000123, 16'h0000, 1'b1, 1'b1, 1'b0, 0, 16'hBEEF, 1'b0, 1'b0, 0, 16'hBEEF};
    vecs[1] = '{2'b11, 24'h00F00D, 16'h1234, 1'b1, 1'b1, 1'b1, 2, 16'h7777, 1'b1, 1'b0, 2, 16'hBEEF};
    vecs[2] = '{2'b11, 24'h00ABCD, 16'h0000, 1'b0, 1'b0, 1'b0, 1, 16'h5A5A, 1'b0, 1'b0, 1, 16'h5A5A};
    vecs[3] = '{2'b10, 24'h123456, 16'h0000, 1'b1, 1'b0, 1'b0, -1, 16'h9999, 1'b1, 1'b1, 3, 16'h5A5A};
    vecs[4] = '{2'b10, 24'hFFFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 3, 16'h0F0F, 1'b1, 1'b0, 3, 16'h0F0F};
    vecs[5] = '{2'b11, 24'h000000, 16'hA5A5, 1'b0, 1'b1, 1'b1, 0, 16'h3333, 1'b0, 1'b0, 0, 16'h0F0F};

    // Reset state.
    tick();
    tick();
    check("reset_outputs", 128'({gnt0, gnt1, done0, done1, err0, err1, mem_start, mem_chipSelect,
          mem_lengthSelect, mem_opSelect, rdata, mem_addr, mem_wdata}), 128'd0);

    // Tie from reset with ack held high: grants alternate 0,1,0,1 every 4 cycles.
    req0 = 1'b1; req1 = 1'b1; mem_ready = 1'b1; mem_ack = 1'b1; mem_rdata = 16'h0101;
    rst = 1'b1;
    n_g = 0; order = 4'b0000; flag = 1'b0;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (gnt0 && gnt1) flag = 1'b1;
      if (gnt0 || gnt1) begin
        if (n_g < 4) order[n_g] = gnt1;
        n_g++;
      end
    end
    check("tie_order", 128'(order), 128'(4'b1010));
    check("tie_grant_count", 128'(n_g), 128'(4));
    check("tie_no_double_gnt", 128'(flag), 128'd0);
    req0 = 1'b0; req1 = 1'b0; mem_ack = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // Vector table: one transaction per entry.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      req0 = v.req[0]; req1 = v.req[1];
      addr0 = v.addr; addr1 = ~v.addr; wdata0 = v.wdata; wdata1 = ~v.wdata;
      cs0 = v.cs; cs1 = v.cs; len0 = v.len; len1 = v.len; op0 = v.op; op1 = v.op;
      mem_ready = 1'b1; mem_ack = 1'b0;
      exp_addr = v.exp_owner ? ~v.addr : v.addr;
      exp_wd   = v.exp_owner ? ~v.wdata : v.wdata;
      if (v.exp_err) exp_pulse = v.exp_owner ? 4'b1000 : 4'b0100;
      else           exp_pulse = v.exp_owner ? 4'b0010 : 4'b0001;
      tick();
      check($sformatf("v%0d_grant", i), 128'({gnt1, gnt0, mem_start}),
            128'({v.exp_owner, ~v.exp_owner, 1'b1}));
      check($sformatf("v%0d_fields", i),
            128'({mem_addr, mem_wdata, mem_chipSelect, mem_lengthSelect, mem_opSelect}),
            128'({exp_addr, exp_wd, v.cs, v.len, v.op}));
      tick();
      check($sformatf("v%0d_wait_entry", i), 128'({gnt1, gnt0, mem_start, mem_addr, mem_wdata}),
            128'({3'b000, exp_addr, exp_wd}));
      w = 0; got = 1'b0;
      while (!got && w < 12) begin
        mem_ack   = (v.ack_wait == w);
        mem_rdata = mem_ack ? v.mrdata : 16'hDEAD;
        tick();
        check($sformatf("v%0d_onehot", i), 128'($countones({gnt0, gnt1, done0, done1, err0, err1}) <= 1), 128'd1);
        got = done0 | done1 | err0 | err1;
        if (!got) w++;
      end
      mem_ack = 1'b0;
      check($sformatf("v%0d_pulse", i), 128'({err1, err0, done1, done0}), 128'(exp_pulse));
      check($sformatf("v%0d_latency", i), 128'(w), 128'(v.exp_w));
      check($sformatf("v%0d_rdata", i), 128'(rdata), 128'(v.exp_rdata));
      req0 = 1'b0; req1 = 1'b0;
      tick();
      check($sformatf("v%0d_quiet", i), 128'({gnt0, gnt1, done0, done1, err0, err1, mem_start}), 128'd0);
    end

    // Write by req0, reset during WAIT: outputs clear at once, no done, tie goes to req0.
    req0 = 1'b1; addr0 = 24'h000777; wdata0 = 16'h55AA; op0 = 1'b1; cs0 = 1'b1; len0 = 1'b1;
    mem_ready = 1'b1; mem_ack = 1'b0;
    tick();
    check("wr_grant", 128'({gnt0, mem_start, mem_wdata, mem_opSelect}), 128'({2'b11, 16'h55AA, 1'b1}));
    tick();
    tick();
    #2;
    rst = 1'b0;
    #1;
    check("wr_reset_outputs", 128'({gnt0, gnt1, done0, done1, err0, err1, mem_start, mem_chipSelect,
          mem_lengthSelect, mem_opSelect, rdata, mem_addr, mem_wdata}), 128'd0);
    req0 = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    flag = 1'b0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (done0 || done1 || err0 || err1) flag = 1'b1;
    end
    check("wr_no_done_after_reset", 128'(flag), 128'd0);
    req0 = 1'b1; req1 = 1'b1; op0 = 1'b0; op1 = 1'b0;
    tick();
    check("wr_tie_after_reset", 128'({gnt1, gnt0}), 128'(2'b01));
    tick();
    mem_ack = 1'b1;
    tick();
    check("wr_tie_done", 128'({done1, done0}), 128'(2'b01));
    mem_ack = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();

    // Backpressure: mem_ready low blocks selection for 10 cycles.
    req1 = 1'b1; addr1 = 24'h0BCDEF; op1 = 1'b0; mem_ready = 1'b0;
    flag = 1'b0;
    for (int t = 0; t < 10; t++) begin
      tick();
      if (gnt0 || gnt1 || mem_start) flag = 1'b1;
    end
    check("bp_blocked", 128'(flag), 128'd0);
    mem_ready = 1'b1;
    tick();
    check("bp_grant", 128'({gnt1, gnt0, mem_start, mem_addr}), 128'({3'b101, 24'h0BCDEF}));
    tick();
    mem_ack = 1'b1; mem_rdata = 16'hC0DE;
    tick();
    check("bp_done", 128'({done1, done0, rdata}), 128'({2'b10, 16'hC0DE}));
    mem_ack = 1'b0; req1 = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
